// File: rtl/processor_pkg.sv
// Shared processor definitions: sequencer state codes decoded by the control unit,
// IR opcode values, and a helper that identifies the memory-access states.
package processor_pkg;

    typedef enum logic [5:0] {
        S_IDLE   = 6'd0,
        S_FETCH1 = 6'd1,
        S_FETCH2 = 6'd2,
        S_FETCH3 = 6'd3,
        S_LDR11  = 6'd4,
        S_LDR12  = 6'd5,
        S_LDR13  = 6'd6,
        S_LDR14  = 6'd7,
        S_LDR21  = 6'd8,
        S_LDR22  = 6'd9,
        S_LDR23  = 6'd10,
        S_LDR24  = 6'd11,
        S_STAC1  = 6'd12,
        S_STAC2  = 6'd13,
        S_STAC3  = 6'd14,
        S_STAC4  = 6'd15,
        S_ADD    = 6'd16,
        S_MUL    = 6'd17,
        S_HALT   = 6'd18
    } state_t;

    localparam int OP_NOP  = 0;
    localparam int OP_LDR1 = 1;
    localparam int OP_LDR2 = 2;
    localparam int OP_STAC = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_MUL  = 5;
    localparam int OP_HALT = 15;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR12) || (s == S_LDR22) || (s == S_STAC3);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stall cycles spent in one memory-access state; expired flags that
// WAIT_MAX stalls have already elapsed without memory responding.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(WAIT_MAX + 1);

    logic [W-1:0] count;

    // clear has priority so a state change always restarts the count at zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == W'(WAIT_MAX));

endmodule

// File: rtl/sequencer_fsm.sv
// Fetch/decode/execute sequencer producing the registered 6-bit state code for
// the control unit, with memory-wait stalls, timeout halt and retire counting.
module sequencer_fsm
    import processor_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic             mem_ready,
    output logic [5:0]       state,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count
);

    // Memory handshake: in a memory state, mem_ready=1 during a cycle completes
    // the access and the state advances at the next edge; mem_ready=0 holds the
    // state and counts one stall. mem_ready is ignored in all other states.

    state_t cur, nxt;
    logic   wait_expired;
    logic   retire;
    logic   bad_op;
    logic   to_fire;
    logic   start_ok;

    assign start_ok = start && ((cur == S_IDLE) || (cur == S_HALT));

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (nxt != cur),
        .enable  (is_mem_state(cur) && !mem_ready),
        .expired (wait_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt     = cur;
        retire  = 1'b0;
        bad_op  = 1'b0;
        to_fire = 1'b0;
        case (cur)
            S_IDLE:   if (start) nxt = S_FETCH1;
            S_FETCH1: nxt = S_FETCH2;
            S_FETCH2: begin
                if (mem_ready) begin
                    nxt = S_FETCH3;
                end else if (wait_expired) begin
                    nxt     = S_HALT;
                    to_fire = 1'b1;
                end
            end
            S_FETCH3: begin
                case (opcode)
                    OPW'(OP_NOP): begin
                        nxt    = S_FETCH1;
                        retire = 1'b1;
                    end
                    OPW'(OP_LDR1): nxt = S_LDR11;
                    OPW'(OP_LDR2): nxt = S_LDR21;
                    OPW'(OP_STAC): nxt = S_STAC1;
                    OPW'(OP_ADD):  nxt = S_ADD;
                    OPW'(OP_MUL):  nxt = S_MUL;
                    OPW'(OP_HALT): nxt = S_HALT;
                    default: begin
                        nxt    = S_FETCH1;
                        bad_op = 1'b1;
                    end
                endcase
            end
            S_LDR11:  nxt = S_LDR12;
            S_LDR12: begin
                if (mem_ready) begin
                    nxt = S_LDR13;
                end else if (wait_expired) begin
                    nxt     = S_HALT;
                    to_fire = 1'b1;
                end
            end
            S_LDR13:  nxt = S_LDR14;
            S_LDR14: begin
                nxt    = S_FETCH1;
                retire = 1'b1;
            end
            S_LDR21:  nxt = S_LDR22;
            S_LDR22: begin
                if (mem_ready) begin
                    nxt = S_LDR23;
                end else if (wait_expired) begin
                    nxt     = S_HALT;
                    to_fire = 1'b1;
                end
            end
            S_LDR23:  nxt = S_LDR24;
            S_LDR24: begin
                nxt    = S_FETCH1;
                retire = 1'b1;
            end
            S_STAC1:  nxt = S_STAC2;
            S_STAC2:  nxt = S_STAC3;
            S_STAC3: begin
                if (mem_ready) begin
                    nxt = S_STAC4;
                end else if (wait_expired) begin
                    nxt     = S_HALT;
                    to_fire = 1'b1;
                end
            end
            S_STAC4: begin
                nxt    = S_FETCH1;
                retire = 1'b1;
            end
            S_ADD: begin
                nxt    = S_FETCH1;
                retire = 1'b1;
            end
            S_MUL: begin
                nxt    = S_FETCH1;
                retire = 1'b1;
            end
            S_HALT:   if (start) nxt = S_FETCH1;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done        <= 1'b0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            instr_count <= '0;
        end else begin
            done    <= (nxt == S_HALT) && (cur != S_HALT);
            illegal <= bad_op;
            if (to_fire) begin
                timeout <= 1'b1;
            end else if (start_ok) begin
                timeout <= 1'b0;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign state = cur;
    assign busy  = (cur != S_IDLE) && (cur != S_HALT);

endmodule

// File: tb/tb_sequencer_fsm.sv
// Directed bench for sequencer_fsm: walks hand-computed state sequences and
// checks each point with immediate assertions; a CNT_W=2 copy checks wrap.
module tb_sequencer_fsm;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  opcode;
    logic        mem_ready;

    logic [5:0]  state;
    logic        busy, done, illegal, timeout;
    logic [15:0] instr_count;

    logic [5:0]  state2;
    logic        busy2, done2, illegal2, timeout2;
    logic [1:0]  instr_count2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sequencer_fsm #(.OPW(4), .CNT_W(16), .WAIT_MAX(15)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .state       (state),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .timeout     (timeout),
        .instr_count (instr_count)
    );

    sequencer_fsm #(.OPW(4), .CNT_W(2), .WAIT_MAX(15)) dut2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .state       (state2),
        .busy        (busy2),
        .done        (done2),
        .illegal     (illegal2),
        .timeout     (timeout2),
        .instr_count (instr_count2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        opcode    = 4'd0;
        mem_ready = 1'b0;
        #3;
        check("reset_state", state, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", instr_count, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // ADD with memory always ready
        start = 1'b1; opcode = 4'd4; mem_ready = 1'b1;
        tick(); check("add_fetch1", state, 1); check("add_busy", busy, 1);
        start = 1'b0;
        tick(); check("add_fetch2", state, 2);
        tick(); check("add_fetch3", state, 3);
        tick(); check("add_exec", state, 16); check("add_count_pre", instr_count, 0);
        tick(); check("add_back_fetch1", state, 1); check("add_count", instr_count, 1);

        // LDR1 with 3 stalls in ldr12
        opcode = 4'd1;
        tick(); check("ldr_fetch2", state, 2);
        tick(); check("ldr_fetch3", state, 3);
        tick(); check("ldr11", state, 4);
        mem_ready = 1'b0;
        tick(); check("ldr12_enter", state, 5);
        tick(); check("ldr12_hold1", state, 5);
        tick(); check("ldr12_hold2", state, 5);
        tick(); check("ldr12_hold3", state, 5);
        mem_ready = 1'b1;
        tick(); check("ldr13", state, 6);
        tick(); check("ldr14", state, 7); check("ldr_count_pre", instr_count, 1);
        tick(); check("ldr_fetch1", state, 1); check("ldr_count", instr_count, 2);
        check("ldr_timeout", timeout, 0);

        // fetch2 timeout: 15 stalls held, next cycle halts
        mem_ready = 1'b0;
        tick(); check("to_fetch2", state, 2);
        for (int i = 0; i < 15; i++) tick();
        check("to_still_fetch2", state, 2);
        check("to_not_yet", timeout, 0);
        tick();
        check("to_halt", state, 18); check("to_flag", timeout, 1);
        check("to_done", done, 1); check("to_busy", busy, 0);
        check("to_count", instr_count, 2);
        tick(); check("to_done_pulse", done, 0); check("to_halt_hold", state, 18);
        check("to_sticky", timeout, 1);

        // restart from halt clears timeout, keeps count
        start = 1'b1;
        tick(); check("restart_fetch1", state, 1); check("restart_timeout", timeout, 0);
        check("restart_count", instr_count, 2);
        start = 1'b0; mem_ready = 1'b1; opcode = 4'd9;
        tick(); tick(); check("ill_fetch3", state, 3); check("ill_pre", illegal, 0);
        tick(); check("ill_fetch1", state, 1); check("ill_pulse", illegal, 1);
        check("ill_count", instr_count, 2);
        opcode = 4'd0;
        tick(); check("ill_pulse_end", illegal, 0); check("nop_fetch2", state, 2);
        tick();
        tick(); check("nop_fetch1", state, 1); check("nop_count", instr_count, 3);

        // HALT instruction, then start resumes
        opcode = 4'd15;
        tick(); tick();
        tick(); check("halt_state", state, 18); check("halt_done", done, 1);
        check("halt_timeout", timeout, 0); check("halt_count", instr_count, 3);
        start = 1'b1;
        tick(); check("halt_done_end", done, 0); check("halt_resume", state, 1);
        check("halt_keep_count", instr_count, 3);
        start = 1'b0;

        // STAC interrupted by asynchronous reset in stac2
        opcode = 4'd3;
        tick(); tick(); tick(); check("stac1", state, 12);
        tick(); check("stac2", state, 13);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", state, 0); check("arst_busy", busy, 0);
        check("arst_done", done, 0); check("arst_illegal", illegal, 0);
        check("arst_timeout", timeout, 0); check("arst_count", instr_count, 0);
        check("arst_count2", instr_count2, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // five ADDs: narrow counter wraps 3 -> 0 -> 1
        start = 1'b1; opcode = 4'd4; mem_ready = 1'b1;
        tick(); check("wrap_fetch1", state2, 1);
        start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick(); tick(); tick(); tick();
            check("wrap_count2", instr_count2, n % 4);
        end
        check("wrap_count16", instr_count, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sequencer_fsm.md
Name: sequencer_fsm

Overview:
- Generates the 6-bit state code that the processor's control unit decodes into its 20-bit control word.
- Runs the fetch, decode and execute sequence from the opcode latched in the instruction register.
- Stalls in memory-access states until memory signals ready, and halts on timeout or a HALT instruction.
- Sits between the IR/memory handshake and the control unit's state input.

Parameters:
- OPW, 4, opcode width taken from the IR.
- CNT_W, 16, width of the retired-instruction counter.
- WAIT_MAX, 15, maximum stall cycles in one memory state before timeout (legal 1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; starts execution from idle or halt.
- opcode  in  OPW  IR opcode field; sampled only in fetch3.
- mem_ready  in  1  memory has completed the current access.
- state  out  6  registered state code to the control unit.
- busy  out  1  high in every state except idle and halt.
- done  out  1  one-cycle pulse on entry to halt.
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded.
- timeout  out  1  sticky flag; set on memory-wait expiry, cleared by start or reset.
- instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- State encodings (fixed, must match the control unit):
  - idle 0, fetch1 1, fetch2 2, fetch3 3
  - ldr11..ldr14 4..7, ldr21..ldr24 8..11
  - stac1..stac4 12..15
  - add 16, mul 17, halt 18
  - codes 19..63 are unused and recover to idle on the next edge.
- Reset (async, reset_n=0):
  - state=idle, busy=0, done=0, illegal=0, timeout=0, instr_count=0, wait counter=0.
  - Reset mid-instruction abandons it with no completion side effects.
- idle: start=1 -> fetch1; otherwise hold.
- Fetch: fetch1 -> fetch2 -> fetch3.
  - fetch2 is a memory state.
- fetch3 decodes opcode and selects the next state:
  - 1 -> ldr11, 2 -> ldr21, 3 -> stac1, 4 -> add, 5 -> mul, 15 -> halt.
  - 0 (NOP) -> fetch1; instruction retires.
  - Any other value -> fetch1 with illegal pulse; instruction does not retire.
- Execute chains advance one state per cycle:
  - ldr11..ldr14 then fetch1.
  - ldr21..ldr24 then fetch1.
  - stac1..stac4 then fetch1.
  - add then fetch1; mul then fetch1.
- Memory states are fetch2, ldr12, ldr22 and stac3:
  - They advance only when mem_ready=1 in that cycle; otherwise they hold and the wait counter increments.
  - The wait counter clears on every state change.
  - If the counter reaches WAIT_MAX while mem_ready=0, next state is halt with timeout=1 and a done pulse; the instruction does not retire.
  - mem_ready is ignored in all other states.
- Retire and count:
  - An instruction retires on the transition out of its last execute state (ldr14, ldr24, stac4, add, mul) into fetch1, or on a NOP in fetch3.
  - instr_count increments by 1 per retirement and wraps from 2^CNT_W-1 to 0.
  - HALT does not retire.
- halt:
  - done pulses on the entry edge only.
  - start=1 -> fetch1 and clears timeout; instr_count is not cleared.
- Latency:
  - state is registered: one clock from decision to output.
  - The control unit adds one more clock, so control_out lags state by one cycle.
- Simultaneous events:
  - reset_n dominates everything.
  - Timeout and mem_ready=1 arriving in the same cycle: mem_ready wins and the state advances.
  - start is ignored outside idle and halt.

Decomposition:
- Shared package (processor_pkg) holds:
  - all 6-bit state code constants, shared with the control unit
  - opcode constants: NOP 0, LDR1 1, LDR2 2, STAC 3, ADD 4, MUL 5, HALT 15.
- One sub-module, mem_wait_timer:
  - wait counter with clear/enable inputs and an expired output.
  - parameterised by WAIT_MAX.

Test Plan:
- Reset, then start=1 for 1 cycle, opcode=4, mem_ready=1 -> state sequence 0,1,2,3,16,1; instr_count=1; busy=1 from fetch1 onward.
- opcode=1, mem_ready=0 for 3 cycles in ldr12 then 1 -> state holds 5 for 4 cycles, then 6,7,1; timeout=0; instr_count increments once.
- WAIT_MAX=15, mem_ready held 0 in fetch2 -> after 15 stall cycles state=18, timeout=1, done pulses 1 cycle, busy=0, instr_count unchanged.
- opcode=9 in fetch3 -> illegal pulses 1 cycle, next state=1, instr_count unchanged; opcode=0 -> next state=1, instr_count+1.
- opcode=15 -> state=18, done pulse; start=1 -> state=1, timeout cleared, instr_count preserved.
- reset_n driven low mid-stac2 (state=13), asynchronously -> state=0 and all outputs zero before the next clock edge; CNT_W=2 run of 5 ADDs -> instr_count wraps 3 -> 0 -> 1.
